serial_dip_scanner: RTL and testbench

Parametrised reader for a chain of parallel-in/serial-out shift registers (74HC165-style) carrying DIP switches and push switches. It drives the chain's load and serial clock, deserialises `N_BITS` per scan, debounces across scans and publishes a stable parallel word with a change strobe. It sits between the board switch chain and the CPU's configuration/IO registers, and supports continuous or on-demand scanning.

---
 rtl/serial_dip_scanner_pkg.sv | 28 ++
 rtl/scan_debounce_filter.sv | 58 +++++
 rtl/serial_dip_scanner.sv | 137 +++++++++++++
 tb/tb_serial_dip_scanner.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/serial_dip_scanner_pkg.sv
// rtl/serial_dip_scanner_pkg.sv - shared types, defaults and field map for the switch-chain scanner
// Contents: scan FSM state enum, parameter defaults, field offsets in the
// default 24-bit word, and the bit-placement helper used by the deserialiser.
package serial_dip_scanner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_COMMIT = 2'd3
    } scan_state_t;

    localparam int DEF_N_BITS         = 24;
    localparam int DEF_CLK_DIV        = 2;
    localparam int DEF_DEBOUNCE_SCANS = 3;

    // Board field map of the default 24-bit word.
    localparam int DIP16_LSB   = 8;
    localparam int DIP16_W     = 16;
    localparam int SWITCH5_LSB = 3;
    localparam int SWITCH5_W   = 5;

    // Destination index in the parallel word for the k-th bit shifted in.
    function automatic int bit_index(input int k, input int n, input bit msb_first);
        return msb_first ? (n - 1 - k) : k;
    endfunction

endpackage

// File: rtl/scan_debounce_filter.sv
// rtl/scan_debounce_filter.sv - cross-scan debounce and publish stage
// Ports:
//   i_CLK, i_RESET     : clock, synchronous active-high reset
//   i_RAW [N_BITS]     : word captured by the last scan
//   i_COMMIT           : one-cycle strobe, i_RAW is complete
//   o_DATA [N_BITS]    : published debounced word
//   o_CHANGED          : one-cycle pulse when o_DATA updates
//   o_STABLE_CNT       : consecutive identical scans, saturating
module scan_debounce_filter
    import serial_dip_scanner_pkg::*;
#(
    parameter int N_BITS         = DEF_N_BITS,
    parameter int DEBOUNCE_SCANS = DEF_DEBOUNCE_SCANS,
    localparam int SW            = $clog2(DEBOUNCE_SCANS + 1)
) (
    input  logic              i_CLK,
    input  logic              i_RESET,
    input  logic [N_BITS-1:0] i_RAW,
    input  logic              i_COMMIT,
    output logic [N_BITS-1:0] o_DATA,
    output logic              o_CHANGED,
    output logic [SW-1:0]     o_STABLE_CNT
);

    localparam logic [SW-1:0] CNT_MAX = SW'(DEBOUNCE_SCANS);

    logic [N_BITS-1:0] prev_raw;
    logic [SW-1:0]     cnt_next;

    // A zero count means no scan since reset, so the first scan never
    // matches the reset value of prev_raw.
    always_comb begin
        cnt_next = SW'(1);
        if (o_STABLE_CNT != '0 && i_RAW == prev_raw) begin
            cnt_next = (o_STABLE_CNT >= CNT_MAX) ? CNT_MAX : o_STABLE_CNT + SW'(1);
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            prev_raw     <= '0;
            o_STABLE_CNT <= '0;
            o_DATA       <= '0;
            o_CHANGED    <= 1'b0;
        end else begin
            o_CHANGED <= 1'b0;
            if (i_COMMIT) begin
                prev_raw     <= i_RAW;
                o_STABLE_CNT <= cnt_next;
                if (cnt_next >= CNT_MAX && i_RAW != o_DATA) begin
                    o_DATA    <= i_RAW;
                    o_CHANGED <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/serial_dip_scanner.sv
// rtl/serial_dip_scanner.sv - 74HC165-style switch chain reader with debounce
// Ports:
//   i_CLK, i_RESET     : clock, synchronous active-high reset
//   i_SCAN_EN          : continuous back-to-back scanning while high
//   i_SCAN_REQ         : single-scan request, honoured only when idle
//   i_SDATA            : serial data from the chain
//   o_LOAD_N, o_SCLK   : chain parallel load (active low) and serial clock
//   o_DATA [N_BITS]    : debounced switch word
//   o_CHANGED          : pulse when o_DATA updates
//   o_SCAN_DONE        : pulse at the end of every scan
//   o_BUSY             : high whenever the FSM is not idle
module serial_dip_scanner
    import serial_dip_scanner_pkg::*;
#(
    parameter int N_BITS         = DEF_N_BITS,
    parameter int CLK_DIV        = DEF_CLK_DIV,
    parameter int DEBOUNCE_SCANS = DEF_DEBOUNCE_SCANS,
    parameter int MSB_FIRST      = 1
) (
    input  logic              i_CLK,
    input  logic              i_RESET,
    input  logic              i_SCAN_EN,
    input  logic              i_SCAN_REQ,
    input  logic              i_SDATA,
    output logic              o_LOAD_N,
    output logic              o_SCLK,
    output logic [N_BITS-1:0] o_DATA,
    output logic              o_CHANGED,
    output logic              o_SCAN_DONE,
    output logic              o_BUSY
);

    localparam int PW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(N_BITS + 1);
    localparam int IW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam int SW = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(N_BITS - 1);

    scan_state_t       state;
    logic [PW-1:0]     ph;
    logic [BW-1:0]     bit_cnt;
    logic [N_BITS-1:0] raw;
    logic [IW-1:0]     idx;
    logic [SW-1:0]     stable_cnt;

    always_comb begin
        idx = IW'(bit_index(int'(bit_cnt), N_BITS, MSB_FIRST != 0));
    end

    // All outputs are registered and change together with the state, so
    // o_BUSY is set/cleared on the same edge that leaves/enters IDLE.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            state       <= ST_IDLE;
            ph          <= '0;
            bit_cnt     <= '0;
            raw         <= '0;
            o_LOAD_N    <= 1'b1;
            o_SCLK      <= 1'b0;
            o_SCAN_DONE <= 1'b0;
            o_BUSY      <= 1'b0;
        end else begin
            o_SCAN_DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_SCAN_EN || i_SCAN_REQ) begin
                        state    <= ST_LOAD;
                        ph       <= '0;
                        o_LOAD_N <= 1'b0;
                        o_BUSY   <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (ph == PH_LAST) begin
                        state    <= ST_SHIFT;
                        ph       <= '0;
                        bit_cnt  <= '0;
                        o_LOAD_N <= 1'b1;
                        o_SCLK   <= 1'b0;
                    end else begin
                        ph <= ph + PW'(1);
                    end
                end
                ST_SHIFT: begin
                    if (ph == PH_LAST) begin
                        ph <= '0;
                        if (!o_SCLK) begin
                            // End of low phase: the chain output has settled
                            // since the previous rising edge.
                            raw[idx] <= i_SDATA;
                            o_SCLK   <= 1'b1;
                        end else begin
                            o_SCLK <= 1'b0;
                            if (bit_cnt == BIT_LAST) begin
                                state <= ST_COMMIT;
                            end else begin
                                bit_cnt <= bit_cnt + BW'(1);
                            end
                        end
                    end else begin
                        ph <= ph + PW'(1);
                    end
                end
                ST_COMMIT: begin
                    o_SCAN_DONE <= 1'b1;
                    ph          <= '0;
                    if (i_SCAN_EN) begin
                        state    <= ST_LOAD;
                        o_LOAD_N <= 1'b0;
                    end else begin
                        state  <= ST_IDLE;
                        o_BUSY <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    scan_debounce_filter #(
        .N_BITS         (N_BITS),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_filter (
        .i_CLK        (i_CLK),
        .i_RESET      (i_RESET),
        .i_RAW        (raw),
        .i_COMMIT     (state == ST_COMMIT),
        .o_DATA       (o_DATA),
        .o_CHANGED    (o_CHANGED),
        .o_STABLE_CNT (stable_cnt)
    );

endmodule

// File: tb/tb_serial_dip_scanner.sv
// tb/tb_serial_dip_scanner.sv - directed self-checking bench for serial_dip_scanner
module tb_serial_dip_scanner;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Instance A: defaults, DEBOUNCE_SCANS=1
    logic en_a = 0, req_a = 0, sd_a, load_a, sclk_a, chg_a, done_a, busy_a;
    logic [23:0] data_a, word_a = '0, sr_a = '0;
    logic sp_a = 0;
    // Instance B: defaults, DEBOUNCE_SCANS=3
    logic en_b = 0, req_b = 0, sd_b, load_b, sclk_b, chg_b, done_b, busy_b;
    logic [23:0] data_b, word_b = '0, sr_b = '0;
    logic sp_b = 0;
    // Instance C: 8 bits, CLK_DIV=1, LSB first
    logic en_c = 0, req_c = 0, sd_c, load_c, sclk_c, chg_c, done_c, busy_c;
    logic [7:0] data_c, word_c = '0, sr_c = '0;
    logic sp_c = 0;

    serial_dip_scanner #(.DEBOUNCE_SCANS(1)) dut_a (
        .i_CLK(clk), .i_RESET(rst), .i_SCAN_EN(en_a), .i_SCAN_REQ(req_a), .i_SDATA(sd_a),
        .o_LOAD_N(load_a), .o_SCLK(sclk_a), .o_DATA(data_a), .o_CHANGED(chg_a),
        .o_SCAN_DONE(done_a), .o_BUSY(busy_a));

    serial_dip_scanner #(.DEBOUNCE_SCANS(3)) dut_b (
        .i_CLK(clk), .i_RESET(rst), .i_SCAN_EN(en_b), .i_SCAN_REQ(req_b), .i_SDATA(sd_b),
        .o_LOAD_N(load_b), .o_SCLK(sclk_b), .o_DATA(data_b), .o_CHANGED(chg_b),
        .o_SCAN_DONE(done_b), .o_BUSY(busy_b));

    serial_dip_scanner #(.N_BITS(8), .CLK_DIV(1), .DEBOUNCE_SCANS(1), .MSB_FIRST(0)) dut_c (
        .i_CLK(clk), .i_RESET(rst), .i_SCAN_EN(en_c), .i_SCAN_REQ(req_c), .i_SDATA(sd_c),
        .o_LOAD_N(load_c), .o_SCLK(sclk_c), .o_DATA(data_c), .o_CHANGED(chg_c),
        .o_SCAN_DONE(done_c), .o_BUSY(busy_c));

    // 74HC165 chain models: parallel load while LOAD_N low, shift on SCLK rise.
    assign sd_a = sr_a[23];
    assign sd_b = sr_b[23];
    assign sd_c = sr_c[7];

    always @(posedge clk) begin
        if (!load_a) sr_a <= word_a;
        else if (sclk_a && !sp_a) sr_a <= sr_a << 1;
        sp_a <= sclk_a;
        if (!load_b) sr_b <= word_b;
        else if (sclk_b && !sp_b) sr_b <= sr_b << 1;
        sp_b <= sclk_b;
        if (!load_c) sr_c <= word_c;
        else if (sclk_c && !sp_c) sr_c <= sr_c << 1;
        sp_c <= sclk_c;
    end

    // SCLK monitor on A: counts rising edges and low phases not lasting 2 cycles.
    int rises_a = 0, badlow_a = 0, lowrun_a = 0;
    logic mprev_a = 0;
    always @(negedge clk) begin
        if (!load_a) lowrun_a = 0;
        else if (!sclk_a) lowrun_a++;
        else begin
            if (!mprev_a) begin
                rises_a++;
                if (lowrun_a != 2) badlow_a++;
            end
            lowrun_a = 0;
        end
        mprev_a = sclk_a;
    end

    initial begin
        int cyc, r0, b0, n_load, n_done, nd, nchg, early;
        bit found;

        repeat (3) @(negedge clk);
        check_vec("rst_data", data_a, 0);
        check_vec("rst_load_n", load_a, 1);
        check_vec("rst_sclk", sclk_a, 0);
        check_vec("rst_busy", busy_a, 0);
        check_vec("rst_strobes", {chg_a, done_a}, 0);
        rst = 0;
        @(negedge clk);

        // Single request, MSB first, extra request while busy is ignored.
        word_a = 24'hA5C3F0;
        r0 = rises_a; b0 = badlow_a;
        req_a = 1; cyc = 0;
        do begin
            @(negedge clk); cyc++;
            req_a = (cyc == 50);
        end while (!chg_a && cyc < 300);
        check_vec("t1_latency", cyc, 100);
        check_vec("t1_data", data_a, 24'hA5C3F0);
        check_vec("t1_done_with_chg", done_a, 1);
        check_vec("t1_sclk_rises", rises_a - r0, 24);
        check_vec("t1_bad_low_phase", badlow_a - b0, 0);
        @(negedge clk);
        check_vec("t1_chg_one_cycle", chg_a, 0);
        n_load = 0; n_done = 0;
        repeat (150) begin
            @(negedge clk);
            if (!load_a) n_load++;
            if (done_a) n_done++;
        end
        check_vec("t1_no_extra_load", n_load, 0);
        check_vec("t1_no_extra_done", n_done, 0);
        check_vec("t1_idle_busy", busy_a, 0);

        // Continuous mode dropped during SHIFT bit 10.
        word_a = 24'h5A0F3C;
        en_a = 1;
        @(negedge clk);
        repeat (43) @(negedge clk);
        check_vec("drop_busy_mid", busy_a, 1);
        en_a = 0;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (done_a) found = 1;
        end
        check_vec("drop_done_seen", found, 1);
        check_vec("drop_data", data_a, 24'h5A0F3C);
        check_vec("drop_busy_after", busy_a, 0);
        n_load = 0;
        repeat (30) begin
            @(negedge clk);
            if (!load_a || busy_a) n_load++;
        end
        check_vec("drop_stays_idle", n_load, 0);

        // Reset mid-SHIFT with a published word.
        word_a = 24'h123456;
        req_a = 1; @(negedge clk); req_a = 0;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (done_a) found = 1;
        end
        check_vec("rst2_pre_data", data_a, 24'h123456);
        word_a = 24'hFFFFFF;
        req_a = 1; @(negedge clk); req_a = 0;
        repeat (29) @(negedge clk);
        check_vec("rst2_sclk_high_before", sclk_a, 1);
        rst = 1;
        @(negedge clk);
        check_vec("rst2_data", data_a, 0);
        check_vec("rst2_sclk", sclk_a, 0);
        check_vec("rst2_load_n", load_a, 1);
        check_vec("rst2_busy", busy_a, 0);
        rst = 0;
        repeat (3) @(negedge clk);
        check_vec("rst2_idle", {busy_a, load_a}, 2'b01);

        // Debounce of 3: 0x000001 for 2 scans, then 0x000002 for 3 scans.
        word_b = 24'h000001;
        en_b = 1;
        nd = 0; nchg = 0; early = 0;
        for (int i = 0; i < 700 && nd < 5; i++) begin
            @(negedge clk);
            if (done_b) nd++;
            if (done_b && nd == 2) word_b = 24'h000002;
            if (chg_b) nchg++;
            if (nd < 5 && data_b != 0) early++;
        end
        check_vec("deb_scans", nd, 5);
        check_vec("deb_data", data_b, 24'h000002);
        check_vec("deb_chg_at_done5", chg_b, 1);
        check_vec("deb_chg_count", nchg, 1);
        check_vec("deb_no_early", early, 0);
        en_b = 0;

        // LSB first, 8 bits, CLK_DIV=1: stream 1,0,0,0,0,0,0,0.
        word_c = 8'h80;
        req_c = 1; cyc = 0;
        do begin
            @(negedge clk); cyc++;
            req_c = 0;
        end while (!done_c && cyc < 100);
        check_vec("lsb_latency", cyc, 19);
        check_vec("lsb_data", data_c, 8'h01);
        check_vec("lsb_chg", chg_c, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
